// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - shared types and sizes for the MEM stage access unit
package pipe_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int WORD_W    = 32;
    localparam int RN_W      = 5;
    localparam int TMO_LIMIT = 15;

endpackage

// File: rtl/pipe_mem_tmo.sv
// rtl/pipe_mem_tmo.sv - bus wait counter; hit flags the last allowed wait cycle
module pipe_mem_tmo
    import pipe_mem_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic enter,
    input  logic busy,
    input  logic mack,
    output logic hit
);

    logic [3:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (enter) begin
            cnt <= '0;
        end else if (busy && !mack) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign hit = busy & ~mack & (cnt == 4'(TMO_LIMIT));

endmodule

// File: rtl/pipe_mem_acc.sv
// rtl/pipe_mem_acc.sv - MEM stage: EXE/MEM and MEM/WB registers plus bus access FSM
// Optional bus timeout with sticky merr is built when PIPE_MEM_TIMEOUT_EN is defined.
module pipe_mem_acc
    import pipe_mem_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              ein_valid,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic [WORD_W-1:0] ealu,
    input  logic [WORD_W-1:0] eb,
    input  logic [RN_W-1:0]   ern,
    output logic              estall,
    output logic              mreq,
    output logic              mwe,
    output logic [WORD_W-1:0] maddr,
    output logic [WORD_W-1:0] mwdata,
    input  logic [WORD_W-1:0] mrdata,
    input  logic              mack,
    output logic              wwreg,
    output logic [RN_W-1:0]   wrn,
    output logic [WORD_W-1:0] wdata,
    output logic              merr
);

    state_t            state;
    logic              mwreg, mm2reg, mwmem, mvalid;
    logic [WORD_W-1:0] malu, mb;
    logic [RN_W-1:0]   mrn;
    logic              busy, tmo_hit, advance, enter;

    assign busy    = (state == BUSY);
    // A timeout ends the access like an ack, so upstream may advance on that edge.
    assign estall  = busy & ~mack & ~tmo_hit;
    assign advance = ~estall;
    assign enter   = advance & ein_valid & (em2reg | ewmem);

`ifdef PIPE_MEM_TIMEOUT_EN
    pipe_mem_tmo u_tmo (
        .clock  (clock),
        .resetn (resetn),
        .enter  (enter),
        .busy   (busy),
        .mack   (mack),
        .hit    (tmo_hit)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            merr <= 1'b0;
        end else if (tmo_hit) begin
            merr <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign merr    = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mvalid <= 1'b0;
            malu   <= '0;
            mb     <= '0;
            mrn    <= '0;
        end else if (advance) begin
            state  <= enter ? BUSY : IDLE;
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mvalid <= ein_valid;
            malu   <= ealu;
            mb     <= eb;
            mrn    <= ern;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wwreg <= 1'b0;
            wrn   <= '0;
            wdata <= '0;
        end else if (!busy) begin
            wwreg <= mwreg & mvalid;
            wrn   <= mrn;
            wdata <= malu;
        end else if (mack) begin
            wwreg <= mwreg;
            wrn   <= mrn;
            wdata <= mm2reg ? mrdata : malu;
        end else begin
            wwreg <= 1'b0;
        end
    end

    assign mreq   = busy;
    assign mwe    = busy & mwmem;
    assign maddr  = busy ? {malu[WORD_W-1:2], 2'b00} : '0;
    assign mwdata = busy ? mb : '0;

endmodule

// File: doc/pipe_mem_acc.md
PIPE_MEM_ACC -- requirements
Module: pipe_mem_acc

Interface
REQ-001 clock  in  1  single rising-edge clock for all state.
REQ-002 resetn  in  1  reset, asynchronous, active-low.
REQ-003 ein_valid  in  1  EXE result valid this cycle.
REQ-004 ewreg, em2reg, ewmem  in  1 each  register-write, load and store controls from EXE.
REQ-005 ealu  in  32  ALU result; memory byte address for loads and stores.
REQ-006 eb  in  32  store data.
REQ-007 ern  in  5  destination register number.
REQ-008 estall  out  1  stall upstream; EXE holds its outputs while 1.
REQ-009 mreq, mwe  out  1 each  bus request and write enable.
REQ-010 maddr, mwdata  out  32 each  bus word address and write data.
REQ-011 mrdata  in  32  bus read data, valid with mack.
REQ-012 mack  in  1  bus completion, one cycle per request.
REQ-013 wwreg  out  1  writeback enable to WB.
REQ-014 wrn  out  5  writeback register number.
REQ-015 wdata  out  32  writeback data.
REQ-016 merr  out  1  sticky bus-timeout flag.

Function
REQ-017 EXE/MEM register (mwreg, mm2reg, mwmem, malu, mb, mrn, mvalid) loads at the clock edge when estall=0; it holds while estall=1.
REQ-018 FSM states: IDLE, BUSY; IDLE->BUSY at the capture edge of a valid load/store (em2reg|ewmem); BUSY->IDLE at the edge where mack=1.
REQ-019 While BUSY: mreq=1, mwe=mwmem, maddr={malu[31:2],2'b00}, mwdata=mb; in IDLE all four are 0.
REQ-020 estall = BUSY & ~mack (combinational), so upstream advances in the same cycle as the ack.
REQ-021 Non-memory op in EXE/MEM, IDLE: at the next edge wwreg=mwreg&mvalid, wrn=mrn, wdata=malu.
REQ-022 BUSY & mack edge: wwreg=mwreg, wrn=mrn, wdata = mrdata if mm2reg else malu.
REQ-023 Cycles BUSY & ~mack: MEM/WB loads a bubble (wwreg=0; wrn and wdata hold).
REQ-024 Latency: ALU op = 2 edges from EXE capture to WB; memory op = 2 + N edges, where N = wait cycles before mack.
REQ-025 mack in IDLE is ignored; mrdata is sampled only when BUSY & mack.
REQ-026 Back-to-back memory ops: the op captured at the ack edge re-enters BUSY with no idle gap; mreq stays 1 across the boundary.
REQ-027 mvalid=0 entries never enter BUSY and never assert wwreg.

Reset
REQ-028 resetn low: state=IDLE; all EXE/MEM and MEM/WB registers, wwreg, wrn, wdata and merr are 0 immediately.
REQ-029 Reset during BUSY drops mreq the same instant; the in-flight access is abandoned and a later mack is ignored.

Configuration
REQ-030 PIPE_MEM_TIMEOUT_EN defined: a 4-bit counter clears on BUSY entry and increments on each BUSY & ~mack cycle.
REQ-031 When the count reaches 15 with mack=0: the next edge returns to IDLE, writes a bubble, sets merr=1 (held until reset) and releases estall.
REQ-032 PIPE_MEM_TIMEOUT_EN undefined: BUSY waits for mack indefinitely, merr is tied 0 and no counter exists.

Structure
REQ-033 Package pipe_mem_pkg holds the state type {IDLE,BUSY}, WORD_W=32, RN_W=5 and TMO_LIMIT=15.
REQ-034 One sub-module, pipe_mem_tmo (timeout counter), is instantiated only under PIPE_MEM_TIMEOUT_EN.

Verification
REQ-035 ALU op: ealu=0x1234, ern=5, ewreg=1 -> two edges later wwreg=1, wrn=5, wdata=0x1234; mreq stays 0.
REQ-036 Load, ealu=0x103, mack after 3 waits with mrdata=0xCAFEF00D -> maddr=0x100, estall high 3 cycles, then wdata=0xCAFEF00D, wrn correct.
REQ-037 Store, eb=0xA5A5A5A5, same-cycle mack -> mwe=1, mwdata=0xA5A5A5A5 for one cycle; wwreg=0; no stall.
REQ-038 Load then store back-to-back, each acked immediately -> mreq continuous for 2 cycles, correct addresses in order.
REQ-039 resetn pulsed low during BUSY -> mreq=0 and all outputs 0 immediately; a stray mack after release has no effect.
REQ-040 PIPE_MEM_TIMEOUT_EN with mack never asserted -> 16 BUSY cycles, then IDLE, merr=1, wwreg=0, estall=0.
